// File: rtl/matmul_stream_ctrl.sv
// matmul_stream_ctrl
// Host-side initiator for a float matmul core. Collects a word-serial stream of operand words
// (A then B, row-major), packs them into the core's flat operand buses, resets and starts the
// core, waits for done (with a timeout), then streams the H*W result words back out row-major.
//
// Packing rule for every flat bus: element (i,j) of an h x w matrix sits in slot
// k = h*w-1-(i*w+j), bits [S*(k+1)-1 : S*k], so element (0,0) occupies the MSBs.
//
// Ports
//   clk, rst_n                 clock (posedge) and asynchronous active-low reset
//   soft_clr                   synchronous abort back to IDLE, clears err
//   in_valid/in_ready/in_data  operand word stream (accepted only in LOAD)
//   mm_rst_n, mm_start         registered reset and one-cycle start pulse to the core
//   mm_a, mm_b                 packed A (H x C) and B (C x W) operands
//   mm_done, mm_o              core completion flag and packed H x W result
//   out_valid/out_ready        result word stream handshake
//   out_data, out_last         result word and end-of-frame marker
//   busy                       high outside LOAD and IDLE
//   err                        sticky WAIT timeout flag

module matmul_stream_ctrl #(
    parameter int unsigned S   = 32,
    parameter int unsigned H   = 2,
    parameter int unsigned W   = 2,
    parameter int unsigned C   = 2,
    parameter int unsigned TMO = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             soft_clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [S-1:0]     in_data,
    output logic             mm_rst_n,
    output logic             mm_start,
    output logic [S*H*C-1:0] mm_a,
    output logic [S*C*W-1:0] mm_b,
    input  logic             mm_done,
    input  logic [S*H*W-1:0] mm_o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [S-1:0]     out_data,
    output logic             out_last,
    output logic             busy,
    output logic             err
);

    localparam int unsigned NA   = H * C;
    localparam int unsigned NB   = C * W;
    localparam int unsigned NIN  = NA + NB;
    localparam int unsigned NOUT = H * W;
    localparam int unsigned IW   = $clog2(NIN + 1);
    localparam int unsigned OW   = $clog2(NOUT + 1);
    localparam int unsigned TW   = $clog2(TMO + 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLoad  = 3'd1;
    localparam logic [2:0] StClr   = 3'd2;
    localparam logic [2:0] StKick  = 3'd3;
    localparam logic [2:0] StWait  = 3'd4;
    localparam logic [2:0] StDrain = 3'd5;

    logic [2:0]       r_state;
    logic [2:0]       w_state_d;
    logic [IW-1:0]    r_in_idx;
    logic [OW-1:0]    r_out_idx;
    logic [TW-1:0]    r_timer;
    logic [S*NA-1:0]  r_mm_a;
    logic [S*NB-1:0]  r_mm_b;
    logic [S*NOUT-1:0] r_res;
    logic             r_err;
    logic             r_mm_rst_n;
    logic             r_mm_start;

    logic             w_in_hs;
    logic             w_in_last;
    logic             w_out_hs;
    logic             w_out_last;
    logic             w_timeout;
    logic [S-1:0]     w_out_word;

    assign w_in_hs    = in_valid && (r_state == StLoad);
    assign w_in_last  = (r_in_idx == IW'(NIN - 1));
    assign w_out_hs   = out_ready && (r_state == StDrain);
    assign w_out_last = (r_out_idx == OW'(NOUT - 1));
    assign w_timeout  = (r_timer == TW'(TMO - 1));

    // Next-state logic; soft_clr overrides every transition.
    always_comb begin
        w_state_d = r_state;
        if (soft_clr) begin
            w_state_d = StIdle;
        end else begin
            unique case (r_state)
                StIdle:  w_state_d = StLoad;
                StLoad:  if (w_in_hs && w_in_last) w_state_d = StClr;
                StClr:   w_state_d = StKick;
                StKick:  w_state_d = StWait;
                StWait:  if (mm_done || w_timeout) w_state_d = StDrain;
                StDrain: if (w_out_hs && w_out_last) w_state_d = StLoad;
                default: w_state_d = StIdle;
            endcase
        end
    end

    // Control state, counters and core-facing strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_in_idx   <= '0;
            r_out_idx  <= '0;
            r_timer    <= '0;
            r_err      <= 1'b0;
            r_mm_rst_n <= 1'b0;
            r_mm_start <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            // Core is held in reset during IDLE and CLR; decoded from next state so the
            // output comes straight from a flop.
            r_mm_rst_n <= !((w_state_d == StIdle) || (w_state_d == StClr));
            r_mm_start <= (w_state_d == StKick);
            if (soft_clr) begin
                r_in_idx  <= '0;
                r_out_idx <= '0;
                r_timer   <= '0;
                r_err     <= 1'b0;
            end else begin
                if (w_in_hs) begin
                    r_in_idx <= w_in_last ? '0 : r_in_idx + IW'(1);
                end
                if (r_state == StKick) begin
                    r_timer <= '0;
                end
                if (r_state == StWait && !mm_done) begin
                    if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                if (w_out_hs) begin
                    r_out_idx <= w_out_last ? '0 : r_out_idx + OW'(1);
                end
            end
        end
    end

    // Operand and result registers. soft_clr leaves their contents alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mm_a <= '0;
            r_mm_b <= '0;
            r_res  <= '0;
        end else if (!soft_clr) begin
            if (w_in_hs) begin
                for (int i = 0; i < int'(NA); i++) begin
                    if (r_in_idx == IW'(i)) begin
                        r_mm_a[S*(int'(NA)-1-i) +: S] <= in_data;
                    end
                end
                for (int i = 0; i < int'(NB); i++) begin
                    if (r_in_idx == IW'(int'(NA) + i)) begin
                        r_mm_b[S*(int'(NB)-1-i) +: S] <= in_data;
                    end
                end
            end
            if (r_state == StWait) begin
                if (mm_done) begin
                    r_res <= mm_o;
                end else if (w_timeout) begin
                    r_res <= '0;
                end
            end
        end
    end

    // Result word select; row-major index r maps to slot NOUT-1-r.
    always_comb begin
        w_out_word = '0;
        for (int j = 0; j < int'(NOUT); j++) begin
            if (r_out_idx == OW'(j)) begin
                w_out_word = r_res[S*(int'(NOUT)-1-j) +: S];
            end
        end
    end

    assign in_ready  = (r_state == StLoad);
    assign out_valid = (r_state == StDrain);
    assign out_data  = out_valid ? w_out_word : '0;
    assign out_last  = out_valid && w_out_last;
    assign busy      = (r_state != StLoad) && (r_state != StIdle);
    assign err       = r_err;
    assign mm_rst_n  = r_mm_rst_n;
    assign mm_start  = r_mm_start;
    assign mm_a      = r_mm_a;
    assign mm_b      = r_mm_b;

endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// Directed bench for matmul_stream_ctrl (S=32, H=W=C=2, TMO=16) with a behavioural core stub.
// Stub modes: 0 = result A^B after a programmable delay, 1 = result A (identity B),
// 2 = done never asserted, 3 = done tied high (result A^B).

module tb_matmul_stream_ctrl;

    localparam int unsigned S   = 32;
    localparam int unsigned TMO = 16;

    logic          clk;
    logic          rst_n;
    logic          soft_clr;
    logic          in_valid;
    logic          in_ready;
    logic [S-1:0]  in_data;
    logic          mm_rst_n;
    logic          mm_start;
    logic [127:0]  mm_a;
    logic [127:0]  mm_b;
    logic          mm_done;
    logic [127:0]  mm_o;
    logic          out_valid;
    logic          out_ready;
    logic [S-1:0]  out_data;
    logic          out_last;
    logic          busy;
    logic          err;

    int            n_checks;
    int            n_errors;
    int            stub_mode;
    int            stub_dly;
    int            stub_cnt;
    logic [31:0]   fr [8];
    logic [31:0]   exp_o [4];

    matmul_stream_ctrl #(
        .S  (S),
        .H  (2),
        .W  (2),
        .C  (2),
        .TMO(TMO)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .soft_clr (soft_clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .mm_rst_n (mm_rst_n),
        .mm_start (mm_start),
        .mm_a     (mm_a),
        .mm_b     (mm_b),
        .mm_done  (mm_done),
        .mm_o     (mm_o),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stub
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_cnt <= 0;
        end else if (mm_start) begin
            stub_cnt <= stub_dly;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
        end
    end

    always_comb begin
        mm_done = 1'b0;
        case (stub_mode)
            0, 1:    mm_done = (stub_cnt == 1);
            3:       mm_done = 1'b1;
            default: mm_done = 1'b0;
        endcase
        mm_o = (stub_mode == 1) ? mm_a : (mm_a ^ mm_b);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input bit gaps);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 500) begin
            @(negedge clk);
            in_data  = d;
            in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            acc      = in_valid && in_ready;
            n++;
        end
        if (!acc) check("in_accept_timeout", 128'(acc), 128'(1));
    endtask

    // Ends on the negedge of the cycle after the last accept (the CLR cycle).
    task automatic send_frame(input bit gaps);
        for (int i = 0; i < 8; i++) send_word(fr[i], gaps);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Ends on the negedge after the final handshake (back in LOAD).
    task automatic recv_frame(input bit gaps);
        int k;
        int n;
        bit stalled;
        logic [31:0] held;
        k       = 0;
        n       = 0;
        stalled = 1'b0;
        held    = '0;
        while (k < 4 && n < 1000) begin
            @(negedge clk);
            n++;
            out_ready = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (out_valid) begin
                if (stalled) check("stall_stable", 128'(out_data), 128'(held));
                if (out_ready) begin
                    check("out_data", 128'(out_data), 128'(exp_o[k]));
                    check("out_last", 128'(out_last), 128'(k == 3));
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = out_data;
                end
            end
        end
        if (k < 4) check("out_timeout", 128'(k), 128'(4));
        @(negedge clk);
        out_ready = 1'b0;
        check("no_extra_valid", 128'(out_valid), 128'(0));
    endtask

    task automatic set_xor_expect();
        for (int k = 0; k < 4; k++) exp_o[k] = fr[k] ^ fr[4 + k];
    endtask

    initial begin
        int n;
        n_checks  = 0;
        n_errors  = 0;
        stub_mode = 0;
        stub_dly  = 1;
        rst_n     = 1'b0;
        soft_clr  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_mm_rst_n", 128'(mm_rst_n), 128'(0));
        check("rst_mm_start", 128'(mm_start), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", 128'(out_data), 128'(0));
        check("rst_out_last", 128'(out_last), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        check("rst_mm_a", mm_a, 128'(0));
        check("rst_mm_b", mm_b, 128'(0));
        rst_n = 1'b1;

        // 1: A=[1,2;3,4], B=I
        stub_mode = 1;
        stub_dly  = 2;
        fr = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
               32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000};
        exp_o = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        send_frame(1'b0);
        recv_frame(1'b0);
        check("t1_err", 128'(err), 128'(0));

        // 2: packing observed at the KICK cycle
        stub_mode = 0;
        fr = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};
        exp_o = '{32'h4, 32'h4, 32'h4, 32'hC};
        send_frame(1'b0);
        check("t2_clr_rst_n", 128'(mm_rst_n), 128'(0));
        @(negedge clk);
        check("t2_kick_start", 128'(mm_start), 128'(1));
        check("t2_mm_a", mm_a, 128'h00000001_00000002_00000003_00000004);
        check("t2_mm_b", mm_b, 128'h00000005_00000006_00000007_00000008);
        recv_frame(1'b0);

        // 4: timeout with done held low
        stub_mode = 2;
        exp_o = '{32'h0, 32'h0, 32'h0, 32'h0};
        send_frame(1'b0);
        @(negedge clk);
        check("t4_kick_start", 128'(mm_start), 128'(1));
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (out_valid) break;
            n++;
        end
        check("t4_wait_cycles", 128'(n), 128'(TMO));
        check("t4_err_set", 128'(err), 128'(1));
        recv_frame(1'b0);
        check("t4_in_ready", 128'(in_ready), 128'(1));
        check("t4_err_held", 128'(err), 128'(1));
        stub_mode = 0;
        stub_dly  = 1;
        fr = '{32'hA, 32'hB, 32'hC, 32'hD, 32'h1, 32'h1, 32'h1, 32'h1};
        exp_o = '{32'hB, 32'hA, 32'hD, 32'hC};
        send_frame(1'b0);
        recv_frame(1'b0);
        check("t4_err_sticky", 128'(err), 128'(1));
        soft_clr = 1'b1;
        @(negedge clk);
        soft_clr = 1'b0;
        check("t4_err_cleared", 128'(err), 128'(0));

        // 5: done tied high
        stub_mode = 3;
        fr = '{32'hF0, 32'h0F, 32'hFF, 32'h00, 32'h0F, 32'h0F, 32'h0F, 32'h0F};
        exp_o = '{32'hFF, 32'h00, 32'hF0, 32'h0F};
        send_frame(1'b0);
        check("t5_clr_rst_n", 128'(mm_rst_n), 128'(0));
        check("t5_clr_start", 128'(mm_start), 128'(0));
        @(negedge clk);
        check("t5_kick_rst_n", 128'(mm_rst_n), 128'(1));
        check("t5_kick_start", 128'(mm_start), 128'(1));
        @(negedge clk);
        check("t5_wait_start", 128'(mm_start), 128'(0));
        check("t5_wait_valid", 128'(out_valid), 128'(0));
        @(negedge clk);
        check("t5_drain_valid", 128'(out_valid), 128'(1));
        recv_frame(1'b0);
        check("t5_err", 128'(err), 128'(0));

        // 6a: soft_clr after the third word
        stub_mode = 0;
        stub_dly  = 2;
        send_word(32'h11, 1'b0);
        send_word(32'h22, 1'b0);
        send_word(32'h33, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        soft_clr = 1'b1;
        @(negedge clk);
        soft_clr = 1'b0;
        check("t6_idle_in_ready", 128'(in_ready), 128'(0));
        check("t6_idle_busy", 128'(busy), 128'(0));
        fr = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h1, 32'h2, 32'h3, 32'h4};
        set_xor_expect();
        send_frame(1'b0);
        recv_frame(1'b0);

        // 6b: rst_n pulse during DRAIN
        send_frame(1'b0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_drain_reached", 128'(out_valid), 128'(1));
        rst_n = 1'b0;
        #1;
        check("t6_rst_out_valid", 128'(out_valid), 128'(0));
        check("t6_rst_mm_rst_n", 128'(mm_rst_n), 128'(0));
        check("t6_rst_mm_a", mm_a, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_no_stale_valid", 128'(out_valid), 128'(0));
        fr = '{32'h5, 32'h6, 32'h7, 32'h8, 32'h50, 32'h60, 32'h70, 32'h80};
        set_xor_expect();
        send_frame(1'b0);
        recv_frame(1'b0);

        // 3: 20 random frames with random handshake gaps and core latency
        stub_mode = 0;
        for (int f = 0; f < 20; f++) begin
            stub_dly = $urandom_range(1, 6);
            for (int i = 0; i < 8; i++) fr[i] = $urandom;
            set_xor_expect();
            send_frame(1'b1);
            recv_frame(1'b1);
        end
        check("t3_err", 128'(err), 128'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
